// File: rtl/ofm_packer_pkg.sv
// ============================================================================
// ofm_packer_pkg : shared SYA definitions (FSM encoding, packing geometry)
// Rev 1.0
// ============================================================================
`default_nettype none

package ofm_packer_pkg;

    localparam int unsigned SYA_ACT_WIDTH  = 8;
    localparam int unsigned SYA_SRAM_WIDTH = 128;
    localparam int unsigned NUM_BYTE       = SYA_SRAM_WIDTH / SYA_ACT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sya_state_e;

    function automatic int unsigned num_byte(input int unsigned sram_w, input int unsigned act_w);
        return sram_w / act_w;
    endfunction

    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ofm_packer.sv
// ============================================================================
// ofm_packer : packs PE-row output bytes LSB-first into global-buffer words
// Rev 1.0
// ============================================================================
`default_nettype none

module ofm_packer
    import ofm_packer_pkg::*;
#(
    parameter int ACT_WIDTH  = SYA_ACT_WIDTH,
    parameter int SRAM_WIDTH = SYA_SRAM_WIDTH,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUSYA_Rst,
    input  logic                  CCUSYA_Start,
    input  logic [ADDR_WIDTH-1:0] CCUSYA_CfgBaseAddr,
    input  logic [CNT_WIDTH-1:0]  CCUSYA_CfgNumOut,
    input  logic                  InPsumVld,
    input  logic [ACT_WIDTH-1:0]  InPsum,
    output logic                  OutPsumRdy,
    output logic                  OutWrVld,
    output logic [ADDR_WIDTH-1:0] OutWrAddr,
    output logic [SRAM_WIDTH-1:0] OutWrDat,
    input  logic                  InWrRdy,
    output logic                  OutDone
);

    localparam int NB      = int'(num_byte(SRAM_WIDTH, ACT_WIDTH));
    localparam int IDX_W   = int'(idx_width(NB));
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NB - 1);

    sya_state_e             state_q,   state_d;
    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
    logic [CNT_WIDTH-1:0]   num_q,     num_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic [SRAM_WIDTH-1:0]  pack_q,    pack_d;
    logic                   wr_vld_q,  wr_vld_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [SRAM_WIDTH-1:0]  wr_dat_q,  wr_dat_d;

    logic                   w_word_end;
    logic                   w_rdy;
    logic                   w_accept;
    logic                   w_wr_fire;
    logic [SRAM_WIDTH-1:0]  w_pack_merged;

    // A word-completing byte may only enter if the output stage is free or draining now.
    assign w_word_end = (idx_q == IDX_MAX) || ((cnt_q + CNT_WIDTH'(1)) == num_q);
    assign w_rdy      = (state_q == ST_RUN) && (cnt_q < num_q)
                        && !(w_word_end && wr_vld_q && !InWrRdy);
    assign w_accept   = InPsumVld && w_rdy;
    assign w_wr_fire  = wr_vld_q && InWrRdy;

    always_comb begin
        w_pack_merged = pack_q;
        w_pack_merged[idx_q*ACT_WIDTH +: ACT_WIDTH] = InPsum;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        idx_d     = idx_q;
        pack_d    = pack_q;
        wr_vld_d  = wr_vld_q;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;

        if (w_wr_fire) begin
            wr_vld_d  = 1'b0;
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end

        if (w_accept) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (w_word_end) begin
                // Pack buffer restarts from zero so a short final word is zero-filled.
                wr_vld_d = 1'b1;
                wr_dat_d = w_pack_merged;
                pack_d   = '0;
                idx_d    = '0;
            end else begin
                pack_d = w_pack_merged;
                idx_d  = idx_q + IDX_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (CCUSYA_Start) begin
                    num_d     = CCUSYA_CfgNumOut;
                    wr_addr_d = CCUSYA_CfgBaseAddr;
                    cnt_d     = '0;
                    idx_d     = '0;
                    pack_d    = '0;
                    state_d   = (CCUSYA_CfgNumOut == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wr_fire && (cnt_q == num_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (CCUSYA_Rst) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            num_d     = '0;
            idx_d     = '0;
            pack_d    = '0;
            wr_vld_d  = 1'b0;
            wr_addr_d = '0;
            wr_dat_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            pack_q    <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            pack_q    <= pack_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    assign OutPsumRdy = w_rdy;
    assign OutWrVld   = wr_vld_q;
    assign OutWrAddr  = wr_addr_q;
    assign OutWrDat   = wr_dat_q;
    assign OutDone    = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ofm_packer.sv
// ============================================================================
// tb_ofm_packer : directed self-checking bench for ofm_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ofm_packer;

    logic         clk;
    logic         rst_n;
    logic         CCUSYA_Rst;
    logic         CCUSYA_Start;
    logic [15:0]  CCUSYA_CfgBaseAddr;
    logic [19:0]  CCUSYA_CfgNumOut;
    logic         InPsumVld;
    logic [7:0]   InPsum;
    logic         OutPsumRdy;
    logic         OutWrVld;
    logic [15:0]  OutWrAddr;
    logic [127:0] OutWrDat;
    logic         InWrRdy;
    logic         OutDone;

    int checks   = 0;
    int failures = 0;

    int           cyc = 0;
    int           wr_cyc[$];
    logic [15:0]  wq_addr[$];
    logic [127:0] wq_dat[$];
    int           acc_cyc[$];
    logic [7:0]   acc_b[$];
    int           done_cnt = 0;
    int           done_cyc = -1;

    ofm_packer #(
        .ACT_WIDTH  (8),
        .SRAM_WIDTH (128),
        .ADDR_WIDTH (16),
        .CNT_WIDTH  (20)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .CCUSYA_Rst         (CCUSYA_Rst),
        .CCUSYA_Start       (CCUSYA_Start),
        .CCUSYA_CfgBaseAddr (CCUSYA_CfgBaseAddr),
        .CCUSYA_CfgNumOut   (CCUSYA_CfgNumOut),
        .InPsumVld          (InPsumVld),
        .InPsum             (InPsum),
        .OutPsumRdy         (OutPsumRdy),
        .OutWrVld           (OutWrVld),
        .OutWrAddr          (OutWrAddr),
        .OutWrDat           (OutWrDat),
        .InWrRdy            (InWrRdy),
        .OutDone            (OutDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes are observed half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (rst_n && !CCUSYA_Rst) begin
            if (OutWrVld && InWrRdy) begin
                wr_cyc.push_back(cyc);
                wq_addr.push_back(OutWrAddr);
                wq_dat.push_back(OutWrDat);
            end
            if (InPsumVld && OutPsumRdy) begin
                acc_cyc.push_back(cyc);
                acc_b.push_back(InPsum);
            end
            if (OutDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        cyc++;
    end

    task automatic clear_mon();
        wr_cyc.delete();
        wq_addr.delete();
        wq_dat.delete();
        acc_cyc.delete();
        acc_b.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic start_job(input logic [15:0] base, input logic [19:0] n);
        @(posedge clk); #1;
        CCUSYA_CfgBaseAddr = base;
        CCUSYA_CfgNumOut   = n;
        CCUSYA_Start       = 1'b1;
        @(posedge clk); #1;
        CCUSYA_Start       = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        InPsumVld = 1'b1;
        InPsum    = b;
        @(negedge clk);
        while (!OutPsumRdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!OutPsumRdy) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: byte %h never accepted, ready=%b required 1", b, OutPsumRdy);
        end
        @(posedge clk); #1;
        InPsumVld = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (OutDone) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: OutDone=%b required 1", name, OutDone);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({OutPsumRdy, OutWrVld, OutDone} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: rdy/vld/done=%b required 000", {OutPsumRdy, OutWrVld, OutDone});
        end
        checks++;
        if (OutWrAddr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_addr: got %h required 0000", OutWrAddr);
        end
        checks++;
        if (OutWrDat !== 128'h0) begin
            failures++;
            $display("FAIL reset_dat: got %h required 0", OutWrDat);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({OutPsumRdy, OutWrVld, OutDone} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ctrl: rdy/vld/done=%b required 000", {OutPsumRdy, OutWrVld, OutDone});
        end
    endtask

    task automatic test_async_reset();
        clear_mon();
        InWrRdy = 1'b0;
        start_job(16'h0600, 20'd16);
        for (int k = 0; k < 16; k++) push_byte(8'(192 + k));
        @(negedge clk);
        checks++;
        if (OutWrVld !== 1'b1) begin
            failures++;
            $display("FAIL ar_pending: OutWrVld=%b required 1", OutWrVld);
        end
        #2;
        rst_n   = 1'b0;
        InWrRdy = 1'b1;
        #1;
        checks++;
        if ({OutWrVld, OutPsumRdy, OutDone} !== 3'b000) begin
            failures++;
            $display("FAIL ar_ctrl: vld/rdy/done=%b required 000", {OutWrVld, OutPsumRdy, OutDone});
        end
        checks++;
        if (OutWrAddr !== 16'h0000 || OutWrDat !== 128'h0) begin
            failures++;
            $display("FAIL ar_data: addr=%h dat=%h required 0000/0", OutWrAddr, OutWrDat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wq_addr.size() !== 0 || OutWrVld !== 1'b0 || OutWrAddr !== 16'h0000) begin
            failures++;
            $display("FAIL ar_no_write: writes=%0d vld=%b addr=%h required 0/0/0000",
                     wq_addr.size(), OutWrVld, OutWrAddr);
        end
    endtask

    task automatic test_two_words();
        int bad;
        clear_mon();
        InWrRdy = 1'b1;
        start_job(16'h0010, 20'd32);
        for (int k = 0; k < 32; k++) push_byte(8'(k));
        wait_done("tw");
        checks++;
        if (wq_addr.size() !== 2) begin
            failures++;
            $display("FAIL tw_count: writes=%0d required 2", wq_addr.size());
        end
        checks++;
        if (wq_addr[0] !== 16'h0010 || wq_dat[0] !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            failures++;
            $display("FAIL tw_word0: addr=%h dat=%h required 0010/0f0e..0100", wq_addr[0], wq_dat[0]);
        end
        checks++;
        if (wq_addr[1] !== 16'h0011 || wq_dat[1] !== 128'h1F1E1D1C1B1A19181716151413121110) begin
            failures++;
            $display("FAIL tw_word1: addr=%h dat=%h required 0011/1f1e..1110", wq_addr[1], wq_dat[1]);
        end
        checks++;
        if (wr_cyc[0] !== acc_cyc[15] + 1) begin
            failures++;
            $display("FAIL tw_latency: write cycle %0d required %0d", wr_cyc[0], acc_cyc[15] + 1);
        end
        checks++;
        if (done_cyc !== wr_cyc[1] + 1 || done_cnt !== 1) begin
            failures++;
            $display("FAIL tw_done: done cycle %0d count %0d required %0d / 1",
                     done_cyc, done_cnt, wr_cyc[1] + 1);
        end
        bad = 0;
        for (int k = 0; k < 32; k++) if (acc_b[k] !== 8'(k)) bad++;
        checks++;
        if (bad != 0 || acc_b.size() !== 32) begin
            failures++;
            $display("FAIL tw_bytes: accepted=%0d wrong=%0d required 32/0", acc_b.size(), bad);
        end
    endtask

    task automatic test_partial();
        clear_mon();
        InWrRdy = 1'b1;
        start_job(16'h0100, 20'd5);
        for (int k = 0; k < 5; k++) push_byte(8'(161 + k));
        @(negedge clk);
        checks++;
        if (OutPsumRdy !== 1'b0) begin
            failures++;
            $display("FAIL pt_rdy_after_last: OutPsumRdy=%b required 0", OutPsumRdy);
        end
        wait_done("pt");
        checks++;
        if (wq_addr.size() !== 1 || wq_addr[0] !== 16'h0100) begin
            failures++;
            $display("FAIL pt_addr: writes=%0d addr=%h required 1/0100", wq_addr.size(), wq_addr[0]);
        end
        checks++;
        if (wq_dat[0] !== 128'h0000000000000000000000A5A4A3A2A1) begin
            failures++;
            $display("FAIL pt_dat: got %h required 0..0a5a4a3a2a1", wq_dat[0]);
        end
        checks++;
        if (done_cyc !== wr_cyc[0] + 1) begin
            failures++;
            $display("FAIL pt_done: done cycle %0d required %0d", done_cyc, wr_cyc[0] + 1);
        end
    endtask

    task automatic test_backpressure();
        int bad_hold;
        int bad;
        int t;
        logic [127:0] exp;
        clear_mon();
        InWrRdy  = 1'b0;
        bad_hold = 0;
        t        = 0;
        start_job(16'h0200, 20'd48);
        fork
            begin
                for (int k = 0; k < 48; k++) push_byte(8'(k));
            end
            begin
                @(negedge clk);
                while (!OutWrVld && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                for (int i = 0; i < 20; i++) begin
                    if (i > 0) @(negedge clk);
                    if (OutWrVld !== 1'b1 || OutWrAddr !== 16'h0200 ||
                        OutWrDat !== 128'h0F0E0D0C0B0A09080706050403020100) bad_hold++;
                    if (i == 19) begin
                        checks++;
                        if (acc_b.size() !== 31 || OutPsumRdy !== 1'b0 || InPsum !== 8'h1F) begin
                            failures++;
                            $display("FAIL bp_stall_31: accepted=%0d rdy=%b byte=%h required 31/0/1f",
                                     acc_b.size(), OutPsumRdy, InPsum);
                        end
                        checks++;
                        if (wq_addr.size() !== 0) begin
                            failures++;
                            $display("FAIL bp_early_write: writes=%0d required 0", wq_addr.size());
                        end
                    end
                end
                @(posedge clk); #1;
                InWrRdy = 1'b1;
            end
        join
        wait_done("bp");
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL bp_hold: unstable cycles=%0d required 0", bad_hold);
        end
        checks++;
        if (wq_addr.size() !== 3) begin
            failures++;
            $display("FAIL bp_count: writes=%0d required 3", wq_addr.size());
        end
        bad = 0;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 16; b++) exp[b*8 +: 8] = 8'(w*16 + b);
            if (wq_addr[w] !== 16'(16'h0200 + w) || wq_dat[w] !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_words: wrong words=%0d required 0", bad);
        end
        bad = 0;
        for (int k = 0; k < 48; k++) if (acc_b[k] !== 8'(k)) bad++;
        checks++;
        if (bad != 0 || acc_b.size() !== 48) begin
            failures++;
            $display("FAIL bp_bytes: accepted=%0d wrong=%0d required 48/0", acc_b.size(), bad);
        end
    endtask

    task automatic test_addr_wrap();
        clear_mon();
        InWrRdy = 1'b1;
        start_job(16'hFFFF, 20'd32);
        for (int k = 0; k < 32; k++) push_byte(8'(64 + k));
        wait_done("wr");
        checks++;
        if (wq_addr.size() !== 2 || wq_addr[0] !== 16'hFFFF || wq_addr[1] !== 16'h0000) begin
            failures++;
            $display("FAIL wr_addr: writes=%0d addr0=%h addr1=%h required 2/ffff/0000",
                     wq_addr.size(), wq_addr[0], wq_addr[1]);
        end
        checks++;
        if (wq_dat[1] !== 128'h5F5E5D5C5B5A59585756555453525150) begin
            failures++;
            $display("FAIL wr_dat1: got %h required 5f5e..5150", wq_dat[1]);
        end
    endtask

    task automatic test_soft_clear();
        clear_mon();
        InWrRdy = 1'b1;
        start_job(16'h0300, 20'd16);
        for (int k = 0; k < 7; k++) push_byte(8'(k + 1));
        CCUSYA_Rst = 1'b1;
        @(posedge clk); #1;
        CCUSYA_Rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({OutPsumRdy, OutWrVld, OutDone} !== 3'b000) begin
            failures++;
            $display("FAIL sc_idle: rdy/vld/done=%b required 000", {OutPsumRdy, OutWrVld, OutDone});
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wq_addr.size() !== 0 || done_cnt !== 0) begin
            failures++;
            $display("FAIL sc_quiet: writes=%0d done=%0d required 0/0", wq_addr.size(), done_cnt);
        end
        clear_mon();
        start_job(16'h0400, 20'd16);
        for (int k = 0; k < 16; k++) push_byte(8'(80 + k));
        wait_done("sc");
        checks++;
        if (wq_addr.size() !== 1 || wq_addr[0] !== 16'h0400 ||
            wq_dat[0] !== 128'h5F5E5D5C5B5A59585756555453525150) begin
            failures++;
            $display("FAIL sc_fresh: writes=%0d addr=%h dat=%h required 1/0400/5f5e..5150",
                     wq_addr.size(), wq_addr[0], wq_dat[0]);
        end
    endtask

    task automatic test_zero();
        clear_mon();
        InWrRdy = 1'b1;
        start_job(16'h0500, 20'd0);
        @(negedge clk);
        checks++;
        if (OutDone !== 1'b1 || OutWrVld !== 1'b0 || OutPsumRdy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done/vld/rdy=%b%b%b required 100", OutDone, OutWrVld, OutPsumRdy);
        end
        @(negedge clk);
        checks++;
        if (OutDone !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse: OutDone=%b required 0", OutDone);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wq_addr.size() !== 0 || done_cnt !== 1) begin
            failures++;
            $display("FAIL zero_quiet: writes=%0d done=%0d required 0/1", wq_addr.size(), done_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n              = 1'b0;
        CCUSYA_Rst         = 1'b0;
        CCUSYA_Start       = 1'b0;
        CCUSYA_CfgBaseAddr = '0;
        CCUSYA_CfgNumOut   = '0;
        InPsumVld          = 1'b0;
        InPsum             = '0;
        InWrRdy            = 1'b0;

        test_reset();
        test_async_reset();
        test_two_words();
        test_partial();
        test_backpressure();
        test_addr_wrap();
        test_soft_clear();
        test_zero();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
